// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU encodings: control codes driven into the ALU, alu_op classes and
// R-type funct values. Used by the issue stage and by the ALU itself.
package alu_issue_stage_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_SLT   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam int unsigned REG_ID_W = 5;

endpackage

// File: rtl/alu_issue_stage_dec.sv
// Combinational alu_op/funct decode into an ALU control code; unknown R-type
// functions fall back to ADD and raise illegal.
module alu_ctrl_dec
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_SLT: alu_ctrl = ALU_SLT;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default: begin
            alu_ctrl = ALU_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register with registered ALU control decode and combinational
// MEM/WB operand forwarding onto the ALU inputs.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic                stall,
  input  logic                flush,
  input  logic [1:0]          alu_op,
  input  logic [5:0]          funct,
  input  logic [DATA_W-1:0]   rs_data,
  input  logic [DATA_W-1:0]   rt_data,
  input  logic [DATA_W-1:0]   imm,
  input  logic                alu_src,
  input  logic [4:0]          rs_id,
  input  logic [4:0]          rt_id,
  input  logic                mem_reg_write,
  input  logic [4:0]          mem_rd,
  input  logic [DATA_W-1:0]   mem_result,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_rd,
  input  logic [DATA_W-1:0]   wb_result,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ALU_A,
  output logic [DATA_W-1:0]   ALU_B,
  output logic [2:0]          ALU_Control,
  output logic                ex_illegal
);

  logic [2:0]          dec_ctrl;
  logic                dec_illegal;
  logic                capture;

  logic [DATA_W-1:0]   rs_data_q;
  logic [DATA_W-1:0]   rt_data_q;
  logic [DATA_W-1:0]   imm_q;
  logic [REG_ID_W-1:0] rs_id_q;
  logic [REG_ID_W-1:0] rt_id_q;
  logic                alu_src_q;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  assign id_ready = !stall;
  assign capture  = id_valid && !stall && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ALU_Control <= ALU_ADD;
      ex_illegal  <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_id_q     <= '0;
      rt_id_q     <= '0;
      alu_src_q   <= 1'b0;
    end else if (capture) begin
      ex_valid    <= 1'b1;
      ALU_Control <= dec_ctrl;
      ex_illegal  <= dec_illegal;
      rs_data_q   <= rs_data;
      rt_data_q   <= rt_data;
      imm_q       <= imm;
      rs_id_q     <= rs_id;
      rt_id_q     <= rt_id;
      alu_src_q   <= alu_src;
    end else begin
      // Bubble: operand fields are left holding stale data since nothing consumes them.
      ex_valid    <= 1'b0;
      ALU_Control <= ALU_ADD;
      ex_illegal  <= 1'b0;
    end
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_ID_W-1:0] src_id,
    input logic [DATA_W-1:0]   reg_val,
    input logic                m_we,
    input logic [REG_ID_W-1:0] m_rd,
    input logic [DATA_W-1:0]   m_res,
    input logic                w_we,
    input logic [REG_ID_W-1:0] w_rd,
    input logic [DATA_W-1:0]   w_res
  );
    if (m_we && (m_rd == src_id) && (m_rd != '0))
      return m_res;
    else if (w_we && (w_rd == src_id) && (w_rd != '0))
      return w_res;
    else
      return reg_val;
  endfunction

  // MEM/WB are sampled live so a writeback landing during EX is still seen.
  always_comb begin
    ALU_A = fwd(rs_id_q, rs_data_q, mem_reg_write, mem_rd, mem_result,
                wb_reg_write, wb_rd, wb_result);
    ALU_B = fwd(rt_id_q, rt_data_q, mem_reg_write, mem_rd, mem_result,
                wb_reg_write, wb_rd, wb_result);
    if (alu_src_q)
      ALU_B = imm_q;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: vector table for decode/forwarding plus
// hand sequences for reset, stall/flush and live forwarding updates.
module tb_alu_issue_stage;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_ready, stall, flush;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic              alu_src;
  logic [4:0]        rs_id, rt_id;
  logic              mem_reg_write;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic              ex_valid;
  logic [DATA_W-1:0] ALU_A, ALU_B;
  logic [2:0]        ALU_Control;
  logic              ex_illegal;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .stall         (stall),
    .flush         (flush),
    .alu_op        (alu_op),
    .funct         (funct),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .imm           (imm),
    .alu_src       (alu_src),
    .rs_id         (rs_id),
    .rt_id         (rt_id),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .ex_valid      (ex_valid),
    .ALU_A         (ALU_A),
    .ALU_B         (ALU_B),
    .ALU_Control   (ALU_Control),
    .ex_illegal    (ex_illegal)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs_d, rt_d, im;
    logic        src;
    logic [4:0]  rs_i, rt_i;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_res;
    logic [2:0]  e_ctrl;
    logic        e_ill;
    logic [31:0] e_a, e_b;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input string name, input logic [1:0] op, input logic [5:0] fn,
    input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] im,
    input logic src, input logic [4:0] rs_i, input logic [4:0] rt_i,
    input logic m_we, input logic [4:0] m_rd, input logic [31:0] m_res,
    input logic w_we, input logic [4:0] w_rd, input logic [31:0] w_res,
    input logic [2:0] e_ctrl, input logic e_ill,
    input logic [31:0] e_a, input logic [31:0] e_b);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.rs_d = rs_d; v.rt_d = rt_d;
    v.im = im; v.src = src; v.rs_i = rs_i; v.rt_i = rt_i;
    v.m_we = m_we; v.m_rd = m_rd; v.m_res = m_res;
    v.w_we = w_we; v.w_rd = w_rd; v.w_res = w_res;
    v.e_ctrl = e_ctrl; v.e_ill = e_ill; v.e_a = e_a; v.e_b = e_b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    alu_op = 2'b00; funct = '0; rs_data = '0; rt_data = '0; imm = '0;
    alu_src = 1'b0; rs_id = '0; rt_id = '0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    alu_op = v.op; funct = v.fn; rs_data = v.rs_d; rt_data = v.rt_d;
    imm = v.im; alu_src = v.src; rs_id = v.rs_i; rt_id = v.rt_i;
    mem_reg_write = v.m_we; mem_rd = v.m_rd; mem_result = v.m_res;
    wb_reg_write = v.w_we; wb_rd = v.w_rd; wb_result = v.w_res;
  endtask

  initial begin
    vecs[0]  = mk("op_add", 2'b00, 6'h00, 32'h5, 32'h3, 32'h0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 3'd2, 0, 32'h5, 32'h3);
    vecs[1]  = mk("op_sub", 2'b01, 6'h00, 32'h9, 32'h4, 32'h0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 3'd6, 0, 32'h9, 32'h4);
    vecs[2]  = mk("op_slt", 2'b11, 6'h00, 32'h1, 32'h2, 32'h0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 3'd7, 0, 32'h1, 32'h2);
    vecs[3]  = mk("r_add",  2'b10, 6'b100000, 32'h10, 32'h20, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd2, 0, 32'h10, 32'h20);
    vecs[4]  = mk("r_sub",  2'b10, 6'b100010, 32'h10, 32'h20, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd6, 0, 32'h10, 32'h20);
    vecs[5]  = mk("r_and",  2'b10, 6'b100100, 32'hF0, 32'h3C, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd0, 0, 32'hF0, 32'h3C);
    vecs[6]  = mk("r_or",   2'b10, 6'b100101, 32'hF0, 32'h3C, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd1, 0, 32'hF0, 32'h3C);
    vecs[7]  = mk("r_slt",  2'b10, 6'b101010, 32'h7, 32'h8, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd7, 0, 32'h7, 32'h8);
    vecs[8]  = mk("r_ill",  2'b10, 6'b111111, 32'h7, 32'h8, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd2, 1, 32'h7, 32'h8);
    vecs[9]  = mk("sub_ign_funct", 2'b01, 6'b111111, 32'h7, 32'h8, 32'h0, 0, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 3'd6, 0, 32'h7, 32'h8);
    vecs[10] = mk("fwd_mem_prio", 2'b00, 6'h00, 32'hAA, 32'hBB, 32'h0, 0, 5'd5, 5'd6, 1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 3'd2, 0, 32'h11, 32'hBB);
    vecs[11] = mk("fwd_wb", 2'b00, 6'h00, 32'hAA, 32'hBB, 32'h0, 0, 5'd5, 5'd6, 0, 5'd5, 32'h11, 1, 5'd5, 32'h22, 3'd2, 0, 32'h22, 32'hBB);
    vecs[12] = mk("fwd_r0", 2'b00, 6'h00, 32'hAA, 32'hBB, 32'h0, 0, 5'd0, 5'd0, 1, 5'd0, 32'h11, 1, 5'd0, 32'h22, 3'd2, 0, 32'hAA, 32'hBB);
    vecs[13] = mk("imm_sel", 2'b00, 6'h00, 32'h1, 32'h2, 32'hFFFFFFFC, 1, 5'd1, 5'd7, 1, 5'd7, 32'h33, 0, 5'd0, 0, 3'd2, 0, 32'h1, 32'hFFFFFFFC);
    vecs[14] = mk("fwd_rt_wb", 2'b01, 6'h00, 32'h1, 32'h2, 32'h0, 0, 5'd1, 5'd9, 1, 5'd8, 32'h44, 1, 5'd9, 32'h55, 3'd6, 0, 32'h1, 32'h55);
    vecs[15] = mk("fwd_rt_mem", 2'b11, 6'h00, 32'h1, 32'h2, 32'h0, 0, 5'd1, 5'd9, 1, 5'd9, 32'h66, 1, 5'd9, 32'h77, 3'd7, 0, 32'h1, 32'h66);

    // Reset then idle
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(ALU_Control), 32'd2);
    check("rst_illegal", 32'(ex_illegal), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ex_valid", 32'(ex_valid), 32'd0);
    check("idle_ctrl", 32'(ALU_Control), 32'd2);
    check("idle_a", ALU_A, 32'd0);
    check("idle_b", ALU_B, 32'd0);
    check("idle_id_ready", 32'(id_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) drive_vec(vecs[i]);
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"}, 32'(ex_valid), 32'd1);
      check({vecs[i].name, "_ctrl"}, 32'(ALU_Control), 32'(vecs[i].e_ctrl));
      check({vecs[i].name, "_ill"}, 32'(ex_illegal), 32'(vecs[i].e_ill));
      check({vecs[i].name, "_a"}, ALU_A, vecs[i].e_a);
      check({vecs[i].name, "_b"}, ALU_B, vecs[i].e_b);
    end

    // Forwarding follows MEM/WB of the current cycle, not issue time
    @(negedge clk);
    idle_inputs();
    id_valid = 1'b1; rs_id = 5'd5; rs_data = 32'hAA; rt_id = 5'd6; rt_data = 32'hBB;
    @(posedge clk); #1;
    check("live_a_before", ALU_A, 32'hAA);
    id_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'h11;
    #1;
    check("live_a_mem", ALU_A, 32'h11);
    mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'h99;
    #1;
    check("live_a_drop", ALU_A, 32'hAA);
    check("live_b_wb", ALU_B, 32'h99);

    // Illegal instruction followed by a stall bubble
    @(negedge clk);
    idle_inputs();
    id_valid = 1'b1; alu_op = 2'b10; funct = 6'b111111;
    @(posedge clk); #1;
    check("ill_set", 32'(ex_illegal), 32'd1);
    @(negedge clk) stall = 1'b1;
    #1 check("stall_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #1;
    check("stall_ex_valid", 32'(ex_valid), 32'd0);
    check("stall_illegal", 32'(ex_illegal), 32'd0);
    check("stall_ctrl", 32'(ALU_Control), 32'd2);
    @(negedge clk) begin stall = 1'b0; flush = 1'b1; alu_op = 2'b01; end
    #1 check("flush_id_ready", 32'(id_ready), 32'd1);
    @(posedge clk); #1;
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_ctrl", 32'(ALU_Control), 32'd2);
    @(negedge clk) stall = 1'b1;
    #1 check("both_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #1;
    check("both_ex_valid", 32'(ex_valid), 32'd0);

    // Async reset mid-stream
    @(negedge clk);
    idle_inputs();
    id_valid = 1'b1; alu_op = 2'b01; rs_id = 5'd3; rs_data = 32'h1234;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    check("pre_rst_ctrl", 32'(ALU_Control), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_ctrl", 32'(ALU_Control), 32'd2);
    check("async_rst_a", ALU_A, 32'd0);
    @(posedge clk); #1;
    check("held_rst_valid", 32'(ex_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_capture", 32'(ex_valid), 32'd1);
    check("post_rst_a", ALU_A, 32'h1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the operand and result width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port id_valid  input  1  decode stage presents an instruction this cycle.
REQ-005 The block SHALL have port id_ready  output  1  the stage accepts the presented instruction; equals !stall.
REQ-006 The block SHALL have port stall  input  1  hazard-unit load-use stall request.
REQ-007 The block SHALL have port flush  input  1  branch-taken flush request.
REQ-008 The block SHALL have port alu_op  input  2  operation class: 00 add, 01 sub, 10 R-type (use funct), 11 slt.
REQ-009 The block SHALL have port funct  input  6  R-type function field.
REQ-010 The block SHALL have ports rs_data, rt_data, imm  input  DATA_W each  register-file reads and sign-extended immediate.
REQ-011 The block SHALL have port alu_src  input  1  1 selects imm as operand B.
REQ-012 The block SHALL have ports rs_id, rt_id  input  5 each  source register numbers.
REQ-013 The block SHALL have ports mem_reg_write  input  1, mem_rd  input  5, mem_result  input  DATA_W  MEM-stage writeback candidate.
REQ-014 The block SHALL have ports wb_reg_write  input  1, wb_rd  input  5, wb_result  input  DATA_W  WB-stage writeback candidate.
REQ-015 The block SHALL have ports ex_valid  output  1, ALU_A  output  DATA_W, ALU_B  output  DATA_W, ALU_Control  output  3, ex_illegal  output  1  EX-stage issue to the ALU.

Function
REQ-016 An instruction SHALL be captured into the EX register on a rising edge when id_valid=1, stall=0, flush=0; latency to ALU inputs is exactly one cycle.
REQ-017 On any edge with stall=1, flush=1 (either or both), or id_valid=0, the EX register SHALL load a bubble: ex_valid=0, ALU_Control=3'd2, ex_illegal=0; other fields don't-care.
REQ-018 ALU_Control decode SHALL be: alu_op 00 -> 2 (add); 01 -> 6 (sub); 11 -> 7 (slt); 10 with funct 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 101010 -> 7.
REQ-019 alu_op=10 with any other funct SHALL decode to 2 with ex_illegal=1 for that instruction's EX cycle.
REQ-020 ALU_A SHALL be combinationally forwarded from the registered rs_id/rs_data: mem_result if mem_reg_write and mem_rd==rs_id and mem_rd!=0; else wb_result if wb_reg_write and wb_rd==rs_id and wb_rd!=0; else registered rs_data.
REQ-021 ALU_B SHALL be the registered imm when registered alu_src=1; otherwise rt forwarded by the same rule and priority as REQ-020.
REQ-022 MEM forwarding SHALL take priority over WB when both match; register 0 SHALL never be forwarded.
REQ-023 Forwarding SHALL use the MEM/WB inputs of the current cycle, not values captured at issue.
REQ-024 ex_valid, ALU_Control, ex_illegal and all captured fields SHALL be registered; only the forwarding muxes are combinational.

Reset
REQ-025 While rst=1, asynchronously: ex_valid=0, ALU_Control=3'd2, ex_illegal=0, captured rs_data/rt_data/imm=0, rs_id/rt_id=0, alu_src=0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight instruction; first capture occurs on the first edge after rst deasserts.

Structure
REQ-027 ALU control codes (AND 0, OR 1, ADD 2, SUB 6, SLT 7), alu_op encodings and funct constants SHALL live in a shared package used by this block and the ALU.
REQ-028 The funct/alu_op decode SHALL be a combinational sub-module alu_ctrl_dec instantiated at the EX register input.

Verification
REQ-029 Reset then idle: rst pulse, id_valid=0 -> ex_valid=0, ALU_Control=2, ALU_A=ALU_B=0.
REQ-030 Decode sweep: alu_op=10, funct 100100, rs_data=0xF0, rt_data=0x3C -> next cycle ALU_Control=0, ALU_A=0xF0, ALU_B=0x3C; funct 111111 -> ALU_Control=2, ex_illegal=1.
REQ-031 Forward priority: registered rs_id=5, mem_rd=wb_rd=5, both write, mem_result=0x11, wb_result=0x22 -> ALU_A=0x11; drop mem_reg_write -> ALU_A=0x22; rs_id=0 -> rs_data.
REQ-032 Immediate: alu_op=00, alu_src=1, imm=0xFFFFFFFC, rt matches mem_rd -> ALU_B=0xFFFFFFFC, ALU_Control=2.
REQ-033 Stall/flush: id_valid=1 with stall=1, then flush=1, then both -> ex_valid=0 each following cycle, id_ready=0 only during stall.
REQ-034 Async reset mid-stream: rst asserted between edges while ex_valid=1 -> ex_valid drops to 0 before next edge.
